// File: rtl/imem_pkg.sv
// Shared types for the instruction-memory responder: response beat, grant FSM
// states, error codes and the helper that builds a pipeline entry.
package imem_pkg;

    typedef struct packed {
        logic        valid;
        logic        err;
        logic [31:0] data;
    } imem_resp_t;

    typedef enum logic [0:0] {
        G_IDLE = 1'b0,
        G_WAIT = 1'b1
    } gnt_state_e;

    localparam logic ERR_NONE  = 1'b0;
    localparam logic ERR_FETCH = 1'b1;

    localparam imem_resp_t RESP_EMPTY = '{valid: 1'b0, err: 1'b0, data: 32'h0000_0000};

    // Faulting fetches never leak array contents onto the bus.
    function automatic imem_resp_t make_resp(input logic err, input logic [31:0] word);
        imem_resp_t r;
        r.valid = 1'b1;
        r.err   = err;
        r.data  = (err == ERR_FETCH) ? 32'h0000_0000 : word;
        return r;
    endfunction

endpackage

// File: rtl/imem_resp_pipe.sv
// Fixed-depth response delay line; the last stage is the registered response
// port, so responses leave in exactly the order they were pushed.
module imem_resp_pipe
    import imem_pkg::*;
#(
    parameter int DEPTH = 1
) (
    input  logic       clk,
    input  logic       clear,
    input  imem_resp_t push_data,
    output imem_resp_t tail
);

    imem_resp_t stage_r [DEPTH];

    // Shift every stage one step per cycle; clear drops all in-flight beats.
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_r[i] <= RESP_EMPTY;
            end
        end else begin
            stage_r[0] <= push_data;
            for (int i = 1; i < DEPTH; i++) begin
                stage_r[i] <= stage_r[i-1];
            end
        end
    end

    assign tail = stage_r[DEPTH-1];

endmodule

// File: rtl/imem_responder.sv
// Memory side of the instruction fetch interface: programmable grant wait,
// bounded outstanding requests, fixed-latency in-order responses.
module imem_responder
    import imem_pkg::*;
#(
    parameter int          DEPTH_WORDS     = 1024,
    parameter logic [31:0] BASE_ADDR       = 32'h0000_0000,
    parameter int          GNT_DELAY       = 0,
    parameter int          RVALID_LATENCY  = 1,
    parameter int          MAX_OUTSTANDING = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        instr_req,
    input  logic [31:0] instr_addr,
    output logic        instr_gnt,
    output logic        instr_valid,
    output logic [31:0] instr_rdata,
    output logic        instr_err,
    input  logic        stall_inject,
    input  logic        load_en,
    input  logic [31:0] load_addr,
    input  logic [31:0] load_data
);

    localparam int         AW        = $clog2(DEPTH_WORDS);
    localparam int         OW        = $clog2(MAX_OUTSTANDING + 1);
    localparam logic       NO_WAIT   = (GNT_DELAY == 0) ? 1'b1 : 1'b0;
    localparam logic [3:0] WAIT_LOAD = (GNT_DELAY == 0) ? 4'd0 : 4'(GNT_DELAY - 1);

    gnt_state_e    state_r;
    gnt_state_e    state_nxt_s;
    logic [3:0]    wait_r;
    logic [3:0]    wait_nxt_s;
    logic [OW-1:0] outst_r;
    logic          eligible_s;
    logic          gnt_s;
    logic          fetch_err_s;
    logic [31:0]   fetch_word_s;
    imem_resp_t    push_s;
    imem_resp_t    tail_s;
    logic [31:0]   mem_r [DEPTH_WORDS];

    // BASE_ADDR is aligned to the array size, so the upper address bits alone
    // decide range and the low bits index the array directly.
    function automatic logic addr_ok(input logic [31:0] a);
        return (a[1:0] == 2'b00) && (a[31:AW+2] == BASE_ADDR[31:AW+2]);
    endfunction

    assign eligible_s = ~stall_inject & ((outst_r < OW'(MAX_OUTSTANDING)) | tail_s.valid);

    // Grant FSM state and wait counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= G_IDLE;
            wait_r  <= 4'd0;
        end else begin
            state_r <= state_nxt_s;
            wait_r  <= wait_nxt_s;
        end
    end

    // Grant FSM next state; a dropped request abandons the wait without a grant.
    always_comb begin
        state_nxt_s = state_r;
        wait_nxt_s  = wait_r;
        case (state_r)
            G_IDLE: begin
                if (instr_req && !NO_WAIT) begin
                    state_nxt_s = G_WAIT;
                    wait_nxt_s  = WAIT_LOAD;
                end else begin
                    state_nxt_s = G_IDLE;
                end
            end
            G_WAIT: begin
                if (!instr_req) begin
                    state_nxt_s = G_IDLE;
                    wait_nxt_s  = 4'd0;
                end else if (wait_r != 4'd0) begin
                    wait_nxt_s = wait_r - 4'd1;
                end else if (eligible_s) begin
                    state_nxt_s = G_IDLE;
                end else begin
                    state_nxt_s = G_WAIT;
                end
            end
            default: begin
                state_nxt_s = G_IDLE;
                wait_nxt_s  = 4'd0;
            end
        endcase
    end

    // Grant FSM output.
    always_comb begin
        gnt_s = 1'b0;
        case (state_r)
            G_IDLE: begin
                if (instr_req && NO_WAIT && eligible_s) begin
                    gnt_s = 1'b1;
                end else begin
                    gnt_s = 1'b0;
                end
            end
            G_WAIT: begin
                if (instr_req && (wait_r == 4'd0) && eligible_s) begin
                    gnt_s = 1'b1;
                end else begin
                    gnt_s = 1'b0;
                end
            end
            default: gnt_s = 1'b0;
        endcase
    end

    assign instr_gnt = gnt_s & ~reset;

    // Granted-but-unanswered count; grant and retire in one cycle cancel.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            outst_r <= '0;
        end else begin
            case ({gnt_s, tail_s.valid})
                2'b10:   outst_r <= outst_r + OW'(1);
                2'b01:   outst_r <= outst_r - OW'(1);
                default: outst_r <= outst_r;
            endcase
        end
    end

    // Decode and read at grant; the array read sees pre-edge contents.
    always_comb begin
        fetch_err_s  = addr_ok(instr_addr) ? ERR_NONE : ERR_FETCH;
        fetch_word_s = mem_r[instr_addr[AW+1:2]];
        if (gnt_s) begin
            push_s = make_resp(fetch_err_s, fetch_word_s);
        end else begin
            push_s = RESP_EMPTY;
        end
    end

    // Preload port; contents survive reset.
    always_ff @(posedge clk) begin
        if (load_en && addr_ok(load_addr)) begin
            mem_r[load_addr[AW+1:2]] <= load_data;
        end
    end

    imem_resp_pipe #(
        .DEPTH(RVALID_LATENCY)
    ) u_pipe (
        .clk      (clk),
        .clear    (reset),
        .push_data(push_s),
        .tail     (tail_s)
    );

    assign instr_valid = tail_s.valid;
    assign instr_err   = tail_s.err;
    assign instr_rdata = tail_s.data;

endmodule

// File: tb/tb_imem_responder.sv
// Bench for imem_responder: three configurations driven by directed vectors,
// each watched every cycle by a response-queue model of the memory.
module tb_imem_responder;

    localparam int         NW   = 16;
    localparam logic [6:0] GEXP = 7'b0001011;
    localparam logic [6:0] VEXP = 7'b1011000;

    typedef struct {
        int          due;
        logic        err;
        logic [31:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req [3];
    logic [31:0] addr [3];
    logic        stall [3];
    logic        load_en [3];
    logic [31:0] load_addr [3];
    logic [31:0] load_data [3];
    logic        gnt [3];
    logic        valid [3];
    logic        err [3];
    logic [31:0] rdata [3];

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] base_of(input int k);
        return (k == 1) ? 32'h0000_0100 : 32'h0000_0000;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    for (genvar k = 0; k < 3; k++) begin : g_inst
        localparam int          GD   = (k == 1) ? 3 : 0;
        localparam int          LAT  = (k == 2) ? 3 : 1;
        localparam int          MO   = (k == 0) ? 1 : 2;
        localparam logic [31:0] BASE = (k == 1) ? 32'h0000_0100 : 32'h0000_0000;

        logic [31:0] mmem [NW];
        exp_t        q [$];
        int          cyc = 0;

        imem_responder #(
            .DEPTH_WORDS    (NW),
            .BASE_ADDR      (BASE),
            .GNT_DELAY      (GD),
            .RVALID_LATENCY (LAT),
            .MAX_OUTSTANDING(MO)
        ) dut (
            .clk         (clk),
            .reset       (reset),
            .instr_req   (req[k]),
            .instr_addr  (addr[k]),
            .instr_gnt   (gnt[k]),
            .instr_valid (valid[k]),
            .instr_rdata (rdata[k]),
            .instr_err   (err[k]),
            .stall_inject(stall[k]),
            .load_en     (load_en[k]),
            .load_addr   (load_addr[k]),
            .load_data   (load_data[k])
        );

        // Model: every grant owes one response LAT cycles later, taken from the
        // memory image as it stood before this cycle's preload write.
        always @(negedge clk) begin
            logic        exp_v;
            logic [31:0] off;
            exp_t        e;
            cyc <= cyc + 1;
            if (reset) begin
                q.delete();
                chk($sformatf("i%0d_rst_gnt", k), 32'(gnt[k]), 32'h0);
                chk($sformatf("i%0d_rst_valid", k), 32'(valid[k]), 32'h0);
                chk($sformatf("i%0d_rst_rdata", k), rdata[k], 32'h0);
                chk($sformatf("i%0d_rst_err", k), 32'(err[k]), 32'h0);
            end else begin
                exp_v = (q.size() > 0) && (q[0].due == cyc);
                chk($sformatf("i%0d_valid@%0d", k, cyc), 32'(valid[k]), 32'(exp_v));
                if (exp_v) begin
                    chk($sformatf("i%0d_err@%0d", k, cyc), 32'(err[k]), 32'(q[0].err));
                    chk($sformatf("i%0d_rdata@%0d", k, cyc), rdata[k], q[0].data);
                    void'(q.pop_front());
                end else begin
                    chk($sformatf("i%0d_idle_err@%0d", k, cyc), 32'(err[k]), 32'h0);
                    chk($sformatf("i%0d_idle_rdata@%0d", k, cyc), rdata[k], 32'h0);
                end
                if (gnt[k]) begin
                    chk($sformatf("i%0d_gnt_req@%0d", k, cyc), 32'(req[k]), 32'h1);
                    chk($sformatf("i%0d_gnt_stall@%0d", k, cyc), 32'(stall[k]), 32'h0);
                    chk($sformatf("i%0d_gnt_cap@%0d", k, cyc), 32'(q.size() < MO), 32'h1);
                    off    = addr[k] - BASE;
                    e.err  = (addr[k][1:0] != 2'b00) || (off >= 32'(4 * NW));
                    e.data = e.err ? 32'h0 : mmem[off[5:2]];
                    e.due  = cyc + LAT;
                    q.push_back(e);
                end
            end
            if (load_en[k]) begin
                off = load_addr[k] - BASE;
                if ((load_addr[k][1:0] == 2'b00) && (off < 32'(4 * NW))) begin
                    mmem[off[5:2]] <= load_data[k];
                end
            end
        end
    end

    initial begin
        for (int k = 0; k < 3; k++) begin
            req[k] = 1'b0; addr[k] = 32'h0; stall[k] = 1'b0;
            load_en[k] = 1'b0; load_addr[k] = 32'h0; load_data[k] = 32'h0;
        end
        reset = 1'b1;
        tick();
        req[0] = 1'b1;
        smp();
        chk("rst_gnt_forced", 32'(gnt[0]), 32'h0);
        chk("rst_rdata", rdata[0], 32'h0);
        tick();
        req[0] = 1'b0;
        reset  = 1'b0;

        // Preload all three arrays, then the special words of instance 0.
        for (int w = 0; w < NW; w++) begin
            tick();
            for (int k = 0; k < 3; k++) begin
                load_en[k]   = 1'b1;
                load_addr[k] = base_of(k) + 32'(4 * w);
                load_data[k] = 32'hA000_0000 | (32'(k) << 8) | 32'(w);
            end
        end
        tick();
        for (int k = 0; k < 3; k++) load_en[k] = 1'b0;
        load_en[0] = 1'b1; load_addr[0] = 32'h0000_0000; load_data[0] = 32'hDEAD_BEEF;
        tick();
        load_addr[0] = 32'h0000_0010; load_data[0] = 32'h0000_0000;
        tick();
        load_addr[0] = 32'h0000_0040; load_data[0] = 32'hBAD0_0000;
        tick();
        load_addr[0] = 32'h0000_0006; load_data[0] = 32'hFFFF_FFFF;
        tick();
        load_en[0] = 1'b0;

        // Instance 0: zero wait, latency 1, one outstanding.
        req[0] = 1'b1; addr[0] = 32'h0000_0000;
        smp(); chk("a_gnt_same_cycle", 32'(gnt[0]), 32'h1);
        tick(); req[0] = 1'b0;
        smp();
        chk("a_valid", 32'(valid[0]), 32'h1);
        chk("a_rdata", rdata[0], 32'hDEAD_BEEF);
        chk("a_err", 32'(err[0]), 32'h0);
        for (int i = 1; i <= 3; i++) begin
            tick(); req[0] = 1'b1; addr[0] = 32'(4 * i);
            smp(); chk($sformatf("b2b_gnt%0d", i), 32'(gnt[0]), 32'h1);
            if (i > 1) chk($sformatf("b2b_rdata%0d", i), rdata[0], 32'hA000_0000 | 32'(i - 1));
        end
        tick(); req[0] = 1'b0;
        smp(); chk("b2b_last", rdata[0], 32'hA000_0003);
        tick(); req[0] = 1'b1; addr[0] = 32'h0000_0008; stall[0] = 1'b1;
        smp(); chk("stall_blocks", 32'(gnt[0]), 32'h0);
        tick(); stall[0] = 1'b0;
        smp(); chk("stall_release", 32'(gnt[0]), 32'h1);
        tick(); req[0] = 1'b0;
        smp(); chk("stall_rdata", rdata[0], 32'hA000_0002);

        tick(); req[0] = 1'b1; addr[0] = 32'h0000_0002;
        smp(); chk("mis_gnt", 32'(gnt[0]), 32'h1);
        tick(); addr[0] = 32'h0000_0040;
        smp();
        chk("oor_gnt", 32'(gnt[0]), 32'h1);
        chk("mis_err", 32'(err[0]), 32'h1);
        chk("mis_rdata", rdata[0], 32'h0);
        tick(); req[0] = 1'b0;
        smp();
        chk("oor_err", 32'(err[0]), 32'h1);
        chk("oor_rdata", rdata[0], 32'h0);
        tick(); smp();
        tick(); req[0] = 1'b1; addr[0] = 32'h0000_000C;
        smp(); chk("count_drained", 32'(gnt[0]), 32'h1);
        tick(); req[0] = 1'b0;
        smp();

        tick(); req[0] = 1'b1; addr[0] = 32'h0000_0010;
        load_en[0] = 1'b1; load_addr[0] = 32'h0000_0010; load_data[0] = 32'h1111_1111;
        smp(); chk("rbw_gnt", 32'(gnt[0]), 32'h1);
        tick(); req[0] = 1'b0; load_en[0] = 1'b0;
        smp(); chk("rbw_old", rdata[0], 32'h0000_0000);
        tick(); req[0] = 1'b1;
        smp();
        tick(); req[0] = 1'b0;
        smp(); chk("rbw_new", rdata[0], 32'h1111_1111);

        // Instance 1: three-cycle grant wait at base 0x100.
        tick(); req[1] = 1'b1; addr[1] = 32'h0000_0104;
        for (int c = 0; c < 4; c++) begin
            smp(); chk($sformatf("wait_gnt_c%0d", c), 32'(gnt[1]), 32'(c == 3));
            if (c < 3) tick();
        end
        tick(); req[1] = 1'b0;
        smp(); chk("wait_rdata", rdata[1], 32'hA000_0101);
        tick(); req[1] = 1'b1; addr[1] = 32'h0000_0108;
        for (int c = 0; c < 5; c++) begin
            smp(); chk($sformatf("wstall_gnt_c%0d", c), 32'(gnt[1]), 32'(c == 4));
            if (c < 4) begin
                tick(); stall[1] = (c == 2);
            end
        end
        tick(); req[1] = 1'b0;
        smp(); chk("wstall_rdata", rdata[1], 32'hA000_0102);
        tick(); req[1] = 1'b1; addr[1] = 32'h0000_010C;
        smp(); chk("drop_c0", 32'(gnt[1]), 32'h0);
        tick();
        smp(); chk("drop_c1", 32'(gnt[1]), 32'h0);
        tick(); req[1] = 1'b0;
        smp(); chk("drop_c2", 32'(gnt[1]), 32'h0);
        tick(); req[1] = 1'b1;
        for (int c = 3; c < 7; c++) begin
            smp(); chk($sformatf("drop_gnt_c%0d", c), 32'(gnt[1]), 32'(c == 6));
            if (c < 6) tick();
        end
        tick(); req[1] = 1'b0;
        smp(); chk("drop_rdata", rdata[1], 32'hA000_0103);

        // Instance 2: latency 3, two outstanding.
        for (int c = 0; c < 7; c++) begin
            tick();
            req[2]  = (c < 4);
            addr[2] = (c < 3) ? 32'(4 * c) : 32'h0000_0008;
            smp();
            chk($sformatf("lat_gnt_c%0d", c), 32'(gnt[2]), 32'(GEXP[c]));
            chk($sformatf("lat_valid_c%0d", c), 32'(valid[2]), 32'(VEXP[c]));
            if (VEXP[c]) begin
                chk($sformatf("lat_rdata_c%0d", c), rdata[2],
                    32'hA000_0200 + ((c == 3) ? 32'd0 : (c == 4) ? 32'd1 : 32'd2));
            end
        end
        tick(); req[2] = 1'b1; addr[2] = 32'h0000_0014;
        smp(); chk("wag_gnt", 32'(gnt[2]), 32'h1);
        tick(); req[2] = 1'b0;
        load_en[2] = 1'b1; load_addr[2] = 32'h0000_0014; load_data[2] = 32'h5555_5555;
        smp();
        tick(); load_en[2] = 1'b0;
        smp();
        tick();
        smp();
        chk("wag_valid", 32'(valid[2]), 32'h1);
        chk("wag_old_data", rdata[2], 32'hA000_0205);

        tick(); req[2] = 1'b1; addr[2] = 32'h0000_0000;
        smp(); chk("inflight_gnt0", 32'(gnt[2]), 32'h1);
        tick(); addr[2] = 32'h0000_0004;
        smp(); chk("inflight_gnt1", 32'(gnt[2]), 32'h1);
        tick(); req[2] = 1'b0; reset = 1'b1;
        smp();
        tick(); reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            smp(); chk($sformatf("post_rst_valid%0d", i), 32'(valid[2]), 32'h0);
            tick();
        end
        req[2] = 1'b1; addr[2] = 32'h0000_0014;
        smp(); chk("post_rst_gnt", 32'(gnt[2]), 32'h1);
        tick(); req[2] = 1'b0;
        smp();
        tick(); smp();
        tick(); smp();
        chk("post_rst_valid", 32'(valid[2]), 32'h1);
        chk("post_rst_rdata", rdata[2], 32'h5555_5555);

        repeat (4) tick();
        smp();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/imem_responder.md
# imem_responder

Instruction-memory responder: the memory-side end of the core's instruction fetch interface (`instr_req`/`instr_addr`/`instr_gnt` request channel, `instr_valid`/`instr_rdata`/`instr_err` response channel). It holds a word-addressed program array and grants fetch requests after a programmable wait. It returns in-order responses at a fixed latency and flags out-of-range or misaligned fetches as errors. It serves as the program memory in core-level simulation and FPGA bring-up, and as a configurable-latency model for stressing the fetch FSM and prefetch FIFO.

## Interface
- `DEPTH_WORDS`, 1024: array size in 32-bit words; power of two.
- `BASE_ADDR`, 32'h0000_0000: byte address of word 0; aligned to 4*DEPTH_WORDS.
- `GNT_DELAY`, 0: cycles `instr_req` must be held before `instr_gnt` (0..15).
- `RVALID_LATENCY`, 1: cycles from grant cycle to `instr_valid` (1..4).
- `MAX_OUTSTANDING`, 2: maximum granted-but-unanswered requests (1..RVALID_LATENCY+1).
- `clk`, input, 1: sole clock; everything is posedge.
- `reset`, input, 1: asynchronous, active-high reset.
- `instr_req`, input, 1: fetch request; held with stable `instr_addr` until granted.
- `instr_addr`, input, 32: byte address of the fetch.
- `instr_gnt`, output, 1: request accepted this cycle; combinational from current state and inputs.
- `instr_valid`, output, 1: response valid; one pulse per grant.
- `instr_rdata`, output, 32: read word; 0 when `instr_valid`=0 or on error.
- `instr_err`, output, 1: fetch error; 0 when `instr_valid`=0.
- `stall_inject`, input, 1: suppresses grant this cycle (verification hook); tie 0 otherwise.
- `load_en`, input, 1: preload write strobe.
- `load_addr`, input, 32: preload byte address; word-aligned and in range, otherwise ignored.
- `load_data`, input, 32: preload word.

## Operation
- Grant FSM has two states:
  - G_IDLE:
    - `instr_req`=1 with GNT_DELAY=0 and grant-eligible: `instr_gnt`=1, stay in G_IDLE.
    - `instr_req`=1 with GNT_DELAY>0: load the wait counter with GNT_DELAY-1 and go to G_WAIT.
  - G_WAIT:
    - Counter decrements each cycle.
    - At 0 and grant-eligible: `instr_gnt`=1, go to G_IDLE.
    - At 0 but not eligible: hold at 0 until eligible.
    - `instr_req` dropping in G_WAIT is a protocol violation: return to G_IDLE, no grant.
- Grant-eligible means `stall_inject`=0 and (outstanding < MAX_OUTSTANDING, or a response retires this same cycle).
- Outstanding counter, width clog2(MAX_OUTSTANDING+1):
  - +1 on grant, -1 on `instr_valid`.
  - Simultaneous grant and retire leave it unchanged.
- On grant:
  - Decode the address. Error if `instr_addr[1:0]`≠0 or the address is outside [BASE_ADDR, BASE_ADDR+4*DEPTH_WORDS).
  - Read the array at index (`instr_addr`-BASE_ADDR)>>2.
  - Push {1, err, err?0:word} into the response pipeline.
- Response pipeline is a RVALID_LATENCY-stage shift register. Its last stage drives `instr_valid`/`instr_err`/`instr_rdata` directly from registers. Responses return strictly in grant order.
- Preload write is committed at the clock edge. If `load_en` and a grant hit the same word in one cycle, the grant returns the old data (read-before-write). A write after a grant never alters that grant's response.
- Reset:
  - Clears the FSM, the counters and all pipeline stages. In-flight responses are dropped and no `instr_valid` follows reset.
  - Array contents are not reset.

## Timing
- Reset values: `instr_gnt`=0, `instr_valid`=0, `instr_rdata`=32'h0, `instr_err`=0. `instr_gnt` is forced 0 while `reset`=1.
- Grant latency: same cycle as `instr_req` rise when GNT_DELAY=0, otherwise GNT_DELAY cycles later, plus any ineligible cycles.
- Response: `instr_valid` asserts exactly RVALID_LATENCY cycles after the grant cycle, for one cycle.
- Back-to-back: with RVALID_LATENCY=1, GNT_DELAY=0, MAX_OUTSTANDING=1, a requester re-issuing on `instr_valid` is granted that same cycle, sustaining one word per cycle.
- No combinational path from `instr_req`/`instr_addr` to `instr_valid`/`instr_rdata`.

## Structure
- Package `imem_pkg`:
  - `imem_resp_t` struct {valid, err, data[31:0]}.
  - Grant-FSM state enum (G_IDLE, G_WAIT).
  - Localparams for the error-code constants.
- Sub-module `imem_resp_pipe`: parameterised-depth shift register of `imem_resp_t` with asynchronous active-high clear.
- Array as an inferred register/RAM in the top level; the read is combinational at grant and captured into pipeline stage 0.

## Test plan
- GNT_DELAY=0, RVALID_LATENCY=1: preload word 0 = 32'hDEADBEEF; req addr 0x0 -> `instr_gnt` same cycle, `instr_valid`=1 next cycle, rdata=32'hDEADBEEF, err=0.
- GNT_DELAY=3: req held at 0x4 -> `instr_gnt` 3 cycles after req rise; `stall_inject`=1 on the 3rd cycle delays grant by 1.
- RVALID_LATENCY=3, MAX_OUTSTANDING=2: continuous reqs at 0x0, 0x4, 0x8 -> third grant withheld until the first `instr_valid`; responses in order, each exactly 3 cycles after its grant.
- Req 0x2 and req BASE_ADDR+4*DEPTH_WORDS -> both respond with err=1, rdata=0; outstanding count returns to 0.
- `load_en` to 0x10 with 32'h1111_1111 in the same cycle as a grant of 0x10 holding 32'h0 -> response 32'h0; next fetch of 0x10 returns 32'h1111_1111.
- Assert `reset` with 2 responses in flight -> no `instr_valid` afterwards; the first post-reset fetch is granted normally and preloaded data is intact.
